// File: rtl/dffrs_bank_arbiter_if.sv
// Request/ack and shared register-bank control bundle for dffrs_bank_arbiter.
// The slave side is the arbiter; the master side is the client/bank environment.
interface dffrs_bank_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [W-1:0]   rdata;
  logic           busy;
  logic           bank_e;
  logic [W-1:0]   bank_d;
  logic           bank_r;
  logic           bank_s;
  logic [W-1:0]   bank_q;

  modport slave (
    input  req, op, wdata, bank_q,
    output ack, rdata, busy, bank_e, bank_d, bank_r, bank_s
  );

  modport master (
    output req, op, wdata, bank_q,
    input  ack, rdata, busy, bank_e, bank_d, bank_r, bank_s
  );
endinterface

// File: rtl/dffrs_bank_arbiter.sv
// Round-robin arbiter that time-shares one dffrs register bank between N clients,
// issuing one r/s/e/d operation per grant and returning the pre-op bank value.
module dffrs_bank_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 8,
  parameter bit          CLR_ON_RST = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  dffrs_bank_arbiter_if.slave bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_ACK} state_t;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
  logic [PW-1:0]  r_win, w_win_nxt;
  logic [N-1:0]   r_ack, w_ack_nxt;
  logic [W-1:0]   r_rdata, w_rdata_nxt;
  logic [W-1:0]   r_bank_d, w_bank_d_nxt;
  logic           r_bank_e, w_bank_e_nxt;
  logic           r_bank_s, w_bank_s_nxt;
  logic           r_bank_r, w_bank_r_nxt;

  logic [N-1:0]   w_req_eff;
  logic           w_gvalid;
  logic [PW-1:0]  w_gidx;
  logic [1:0]     w_gop;
  logic [W-1:0]   w_gdata;

  // Two passes: first the requesters at or above the pointer, then wrap to 0.
  always_comb begin
    w_req_eff = bus.req;
    if (r_state == S_ACK) w_req_eff = bus.req & ~r_ack;
    w_gvalid = 1'b0;
    w_gidx   = '0;
    w_gop    = '0;
    w_gdata  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_gvalid && w_req_eff[i] && (PW'(i) >= r_ptr)) begin
        w_gvalid = 1'b1;
        w_gidx   = PW'(i);
        w_gop    = bus.op[2*i +: 2];
        w_gdata  = bus.wdata[W*i +: W];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_gvalid && w_req_eff[i]) begin
        w_gvalid = 1'b1;
        w_gidx   = PW'(i);
        w_gop    = bus.op[2*i +: 2];
        w_gdata  = bus.wdata[W*i +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_ack_nxt    = '0;
    w_rdata_nxt  = r_rdata;
    w_bank_d_nxt = '0;
    w_bank_e_nxt = 1'b0;
    w_bank_s_nxt = 1'b0;
    w_bank_r_nxt = 1'b0;
    case (r_state)
      S_INIT: w_state_nxt = S_IDLE;
      S_IDLE, S_ACK: begin
        if (w_gvalid) begin
          w_state_nxt = S_ISSUE;
          w_win_nxt   = w_gidx;
          w_ptr_nxt   = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
          case (w_gop)
            2'b00: begin
              w_bank_e_nxt = 1'b1;
              w_bank_d_nxt = w_gdata;
            end
            2'b01:   w_bank_s_nxt = 1'b1;
            2'b10:   w_bank_r_nxt = 1'b1;
            default: ;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt      = S_ACK;
        w_rdata_nxt      = bus.bank_q;
        w_ack_nxt[r_win] = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_ON_RST ? S_INIT : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_ack    <= '0;
      r_rdata  <= '0;
      r_bank_d <= '0;
      r_bank_e <= 1'b0;
      r_bank_s <= 1'b0;
      r_bank_r <= 1'b0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_win    <= w_win_nxt;
      r_ack    <= w_ack_nxt;
      r_rdata  <= w_rdata_nxt;
      r_bank_d <= w_bank_d_nxt;
      r_bank_e <= w_bank_e_nxt;
      r_bank_s <= w_bank_s_nxt;
      r_bank_r <= w_bank_r_nxt;
    end
  end

  assign bus.ack    = r_ack;
  assign bus.rdata  = r_rdata;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.bank_e = r_bank_e;
  assign bus.bank_d = r_bank_d;
  assign bus.bank_s = r_bank_s;
  // INIT clear must be visible in the first cycle after release, but not while held in reset.
  assign bus.bank_r = r_bank_r | ((r_state == S_INIT) && rst_n);

endmodule

// File: tb/tb_dffrs_bank_arbiter.sv
// Directed bench for dffrs_bank_arbiter with a behavioural dffrs bank model on the bank lines.
module tb_dffrs_bank_arbiter;

  logic clk;
  logic rst_n;
  logic bank_preset;
  logic [7:0] r_bank;
  int unsigned n_checks;
  int unsigned n_errors;

  dffrs_bank_arbiter_if #(.N(4), .W(8)) bif ();

  dffrs_bank_arbiter #(.N(4), .W(8), .CLR_ON_RST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dffrs bank: reset over set over enable; untouched by rst_n.
  always @(posedge clk) begin
    if (bank_preset)     r_bank <= 8'hA5;
    else if (bif.bank_r) r_bank <= 8'h00;
    else if (bif.bank_s) r_bank <= 8'hFF;
    else if (bif.bank_e) r_bank <= bif.bank_d;
  end
  assign bif.bank_q = r_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic single_op(input string tag, input int unsigned i, input logic [1:0] o,
                           input logic [7:0] d, input logic [2:0] exp_ctl, input logic [7:0] exp_d,
                           input logic [7:0] exp_rd, input logic [7:0] exp_bank);
    logic [3:0] onehot;
    onehot = '0;
    onehot[i] = 1'b1;
    bif.req = onehot;
    bif.op[2*i +: 2] = o;
    bif.wdata[8*i +: 8] = d;
    @(negedge clk);
    check({tag, "_ctl"}, 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'(exp_ctl));
    check({tag, "_d"}, 32'(bif.bank_d), 32'(exp_d));
    check({tag, "_noack"}, 32'(bif.ack), 32'h0);
    @(negedge clk);
    check({tag, "_ack"}, 32'(bif.ack), 32'(onehot));
    check({tag, "_rdata"}, 32'(bif.rdata), 32'(exp_rd));
    check({tag, "_bank"}, 32'(r_bank), 32'(exp_bank));
    check({tag, "_ctl_off"}, 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'h0);
    bif.req = '0;
    @(negedge clk);
    check({tag, "_ack_gone"}, 32'(bif.ack), 32'h0);
    check({tag, "_idle"}, 32'(bif.busy), 32'h0);
  endtask

  initial begin
    int unsigned exp_win [5];
    logic [7:0]  exp_rd  [5];
    logic [3:0]  onehot;
    exp_win = '{0, 1, 2, 3, 0};
    exp_rd  = '{8'h00, 8'h10, 8'h21, 8'h32, 8'h43};
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bank_preset = 1'b1;
    bif.req = '0;
    bif.op = '0;
    bif.wdata = '0;

    // Reset state and INIT clear.
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bif.ack), 32'h0);
    check("rst_rdata", 32'(bif.rdata), 32'h0);
    check("rst_ctl", 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'h0);
    check("rst_d", 32'(bif.bank_d), 32'h0);
    check("rst_busy", 32'(bif.busy), 32'h1);
    bank_preset = 1'b0;
    @(negedge clk);
    check("rst_bank_kept", 32'(r_bank), 32'hA5);
    rst_n = 1'b1;
    #1;
    check("init_r", 32'(bif.bank_r), 32'h1);
    check("init_busy", 32'(bif.busy), 32'h1);
    @(negedge clk);
    check("init_r_off", 32'(bif.bank_r), 32'h0);
    check("init_bank", 32'(r_bank), 32'h00);
    check("init_idle", 32'(bif.busy), 32'h0);

    // Single ops: {e,s,r} expected controls.
    single_op("load2", 2, 2'b00, 8'h3C, 3'b100, 8'h3C, 8'h00, 8'h3C);
    single_op("set1",  1, 2'b01, 8'h77, 3'b010, 8'h00, 8'h3C, 8'hFF);
    single_op("clr3",  3, 2'b10, 8'h77, 3'b001, 8'h00, 8'hFF, 8'h00);
    single_op("load0", 0, 2'b00, 8'h5A, 3'b100, 8'h5A, 8'h00, 8'h5A);
    single_op("read2", 2, 2'b11, 8'hEE, 3'b000, 8'h00, 8'h5A, 8'h5A);

    // Round-robin from reset, all four loading distinct data; requester 0 keeps requesting.
    rst_n = 1'b0;
    bif.req = 4'b1111;
    bif.op = 8'h00;
    bif.wdata = 32'h43322110;
    #1;
    check("rr_rst_ctl", 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rr_init_bank", 32'(r_bank), 32'h00);
    check("rr_init_noack", 32'(bif.ack), 32'h0);
    for (int k = 0; k < 5; k++) begin
      onehot = '0;
      onehot[exp_win[k]] = 1'b1;
      @(negedge clk);
      check("rr_issue_e", 32'(bif.bank_e), 32'h1);
      check("rr_issue_noack", 32'(bif.ack), 32'h0);
      @(negedge clk);
      check("rr_ack", 32'(bif.ack), 32'(onehot));
      check("rr_rdata", 32'(bif.rdata), 32'(exp_rd[k]));
      if (k != 0) bif.req[exp_win[k]] = 1'b0;
    end
    @(negedge clk);
    check("rr_done_ack", 32'(bif.ack), 32'h0);
    check("rr_done_idle", 32'(bif.busy), 32'h0);
    check("rr_bank", 32'(r_bank), 32'h10);

    // Mask on ACK exit: holders keep req one cycle past their ack.
    bif.op = 8'hFF;
    bif.req = 4'b1010;
    @(negedge clk);
    check("mask_read_ctl", 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'h0);
    check("mask_busy", 32'(bif.busy), 32'h1);
    @(negedge clk);
    check("mask_ack1", 32'(bif.ack), 32'h2);
    check("mask_rd1", 32'(bif.rdata), 32'h10);
    @(negedge clk);
    check("mask_issue3", 32'(bif.ack), 32'h0);
    bif.req[1] = 1'b0;
    @(negedge clk);
    check("mask_ack3", 32'(bif.ack), 32'h8);
    @(negedge clk);
    check("mask_no_regrant", 32'(bif.busy), 32'h0);
    check("mask_ack_off", 32'(bif.ack), 32'h0);
    bif.req = '0;
    @(negedge clk);
    check("mask_stay_idle", 32'({bif.busy, bif.ack}), 32'h0);

    // Reset in the middle of a LOAD FF.
    single_op("load0b", 0, 2'b00, 8'h11, 3'b100, 8'h11, 8'h10, 8'h11);
    bif.op[5:4] = 2'b00;
    bif.wdata[23:16] = 8'hFF;
    bif.req = 4'b0100;
    @(negedge clk);
    check("mid_issue_e", 32'(bif.bank_e), 32'h1);
    check("mid_issue_d", 32'(bif.bank_d), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("mid_ctl_drop", 32'({bif.bank_e, bif.bank_s, bif.bank_r}), 32'h0);
    check("mid_d_drop", 32'(bif.bank_d), 32'h0);
    bif.req = '0;
    @(negedge clk);
    check("mid_bank_kept", 32'(r_bank), 32'h11);
    check("mid_noack", 32'(bif.ack), 32'h0);
    rst_n = 1'b1;
    #1;
    check("mid_init_r", 32'(bif.bank_r), 32'h1);
    @(negedge clk);
    check("mid_bank_clr", 32'(r_bank), 32'h00);
    check("mid_final", 32'({bif.busy, bif.ack, bif.bank_r}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dffrs_bank_arbiter.md
# dffrs_bank_arbiter

Round-robin arbiter and sequencer that shares one W-bit bank of dffrs cells (synchronous reset, set, enable and data, reset priority over set, set priority over enable) between N requesters. The block grants one requester at a time, drives the bank's shared r/s/e/d control lines for exactly one clock, and returns the bank's pre-operation value with a one-cycle acknowledge. It sits between the register-bank datapath and the client blocks that load, set, clear or read it.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, bank width in bits
- CLR_ON_RST, 1, when 1 the block issues one bank clear after reset release

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  request per requester; held high until its ack
- op  in  2N  op per requester, bits [2i+1:2i]; 00 LOAD, 01 SET, 10 CLEAR, 11 READ
- wdata  in  N*W  load data per requester, bits [W*i+W-1:W*i]
- ack  out  N  one-hot, one-cycle completion pulse
- rdata  out  W  bank value before the acked op; valid while ack is nonzero
- busy  out  1  high in every state except IDLE
- bank_e  out  1  bank enable
- bank_d  out  W  bank data
- bank_r  out  1  bank synchronous reset, all bits
- bank_s  out  1  bank synchronous set, all bits
- bank_q  in  W  bank outputs

## Operation
- States: INIT, IDLE, ISSUE, ACK. All outputs are registered.
- Reset (rst_n low) clears everything asynchronously, regardless of clk:
  - state goes to INIT if CLR_ON_RST is 1, otherwise to IDLE;
  - ack, rdata, bank_e, bank_d, bank_r and bank_s go to 0;
  - the round-robin pointer is set so that requester 0 has highest priority;
  - the bank itself is not reset by rst_n.
- INIT: bank_r is 1 for one cycle, busy is 1, then the block moves to IDLE. No grant is made in INIT.
- IDLE: if any req bit is set at a clock edge, the block grants the highest-priority set bit and moves to ISSUE.
- Grant and ISSUE:
  - At the grant edge the block latches the winner index, that winner's op and that winner's wdata.
  - At the same edge it loads the bank controls for the latched op:
    - LOAD: bank_e=1, bank_d=wdata.
    - SET: bank_s=1.
    - CLEAR: bank_r=1.
    - READ: all controls 0.
  - The controls are held for exactly the ISSUE cycle. Outside ISSUE and INIT, all bank controls are 0.
  - At the ISSUE exit edge, rdata is loaded from bank_q. This is the value before the bank updates at that same edge. The state moves to ACK.
- ACK: ack[winner] is 1 for one cycle. At the ACK exit edge:
  - the acked requester's req bit is masked for that edge only;
  - if any other req is set, the block grants directly and moves to ISSUE;
  - otherwise it moves to IDLE.
- Round-robin: priority starts at (last winner + 1) mod N and wraps around. The pointer updates at every grant.
- Requester rule: deassert req, or present the next op, in the cycle after ack. op and wdata must be stable while req is high. Changes after the grant edge are ignored.
- Requests that arrive during INIT, ISSUE or ACK wait. No request is dropped.

## Timing
- Request at edge k in IDLE:
  - bank controls are active during cycle k..k+1;
  - the bank updates at edge k+1;
  - ack and rdata are valid during cycle k+1..k+2.
- Back-to-back throughput is one op per 2 cycles (ISSUE, ACK alternating).
- Latency from req to ack is 2 cycles from IDLE. The worst-case wait for a requester with all N requesting is 2N cycles.
- rst_n asserted mid-ISSUE: the controls drop immediately, so the bank does not update at the next edge. No ack is issued and the op is lost; the requester must re-request.
- rst_n deasserted: with CLR_ON_RST=1, bank_r is asserted during the first cycle, so bank_q is 0 after the first edge.

## Test plan
- Reset clear: CLR_ON_RST=1, release rst_n with bank_q=8'hA5. Required: bank_r=1 for exactly 1 cycle, then bank_q=8'h00, busy=0.
- Single LOAD: requester 2, op=00, wdata=8'h3C, bank initially 8'h00. Required:
  - bank_e=1 and bank_d=8'h3C for 1 cycle;
  - ack=4'b0100 two cycles after req;
  - rdata=8'h00, then bank_q=8'h3C.
- SET, CLEAR and READ: SET gives rdata equal to the old value and bank 8'hFF. CLEAR gives rdata=8'hFF and bank 8'h00. READ with bank 8'h5A drives no controls and returns rdata=8'h5A.
- Round-robin: all 4 requesters request simultaneously from reset. Required:
  - ack order 0,1,2,3, one ack every 2 cycles;
  - requester 0 re-requesting after its ack is served after 3.
- Mask on exit: a requester holds req for 1 extra cycle after its ack while another is pending. Required: the other requester is granted next, with no double service.
- Reset mid-op: assert rst_n in ISSUE of a LOAD 8'hFF with bank 8'h11. Required: controls are 0 immediately, no ack, and bank_q stays 8'h11, or becomes 8'h00 after the INIT clear.
